mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single main-memory port between the i-cache refill path and the d-cache refill/writeback path.
- Grants one requester at a time, latches its request, drives the memory address handshake, then steers a LINE_WORDS-beat data burst to or from the winner.
- Sits between both caches and the memory interface. It sequences line transfers only; the caches keep their own hit logic and the pipeline hazard control stays unchanged.

Parameters:
- ADDR_WIDTH, 26: line-address width (word-aligned line base).
- DATA_WIDTH, 32: beat width.
- LINE_WORDS, 4: beats per burst; must be a power of two, ≥1.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- i_req_valid  in  1  i-cache read-line request; held until i_req_ready
- i_req_addr  in  ADDR_WIDTH  i-cache line address
- i_req_ready  out  1  one-cycle grant pulse to i-cache
- i_rdata_valid  out  1  read beat for i-cache
- d_req_valid  in  1  d-cache line request; held until d_req_ready
- d_req_write  in  1  1 = writeback, 0 = refill
- d_req_addr  in  ADDR_WIDTH  d-cache line address
- d_req_ready  out  1  one-cycle grant pulse to d-cache
- d_wdata_valid  in  1  d-cache write beat offered
- d_wdata  in  DATA_WIDTH  write beat
- d_wdata_ready  out  1  write beat accepted
- d_rdata_valid  out  1  read beat for d-cache
- rdata  out  DATA_WIDTH  read beat, shared by both caches (mem_rdata passthrough)
- mem_req_valid  out  1  memory command valid
- mem_req_ready  in  1  memory command accepted
- mem_req_write  out  1  command is a write
- mem_req_addr  out  ADDR_WIDTH  command address
- mem_wdata_valid  out  1  write beat valid
- mem_wdata  out  DATA_WIDTH  write beat
- mem_wdata_ready  in  1  memory accepts write beat
- mem_rdata_valid  in  1  read beat from memory
- mem_rdata  in  DATA_WIDTH  read beat

Behaviour:
- Reset (async, rst=1):
  - State = IDLE, beat counter = 0, latched addr/write = 0, last-grant = I.
  - Every valid/ready output is 0. Address and data outputs are 0.
- States: IDLE, I_CMD, D_CMD, I_READ, D_READ, D_WRITE.
- IDLE:
  - Picks a winner. Fixed priority gives D over I.
  - On a winner, pulses that requester's req_ready for exactly one cycle, latches addr and write (write forced 0 for I), and goes to I_CMD or D_CMD next cycle.
  - No request: stays in IDLE.
- I_CMD / D_CMD:
  - mem_req_valid=1 with the latched addr/write, held stable until mem_req_ready.
  - On handshake, goes to I_READ, D_READ or D_WRITE (chosen by the latched write bit). Counter clears to 0.
- I_READ / D_READ:
  - The granted cache's rdata_valid = mem_rdata_valid (combinational, same cycle). The other cache's rdata_valid = 0.
  - Counter increments on each mem_rdata_valid.
  - On the beat where counter==LINE_WORDS-1, returns to IDLE the next cycle.
- D_WRITE:
  - mem_wdata_valid = d_wdata_valid, mem_wdata = d_wdata, d_wdata_ready = mem_wdata_ready.
  - A beat transfers when both sides are high. Counter increments per transfer.
  - Returns to IDLE after the transfer with counter==LINE_WORDS-1.
- Outside D_WRITE: d_wdata_ready=0 and mem_wdata_valid=0.
- rdata = mem_rdata always.
- Minimum arbitration gap: one IDLE cycle between bursts. An idle-to-command turnaround is therefore 1 cycle.
- Counter: $clog2(LINE_WORDS) bits, minimum 1 bit, wraps to 0 on burst end. LINE_WORDS=1 gives a single-beat burst.
- Boundary conditions:
  - mem_rdata_valid outside a READ state is ignored: no rdata_valid to either cache, no counter change.
  - Requests arriving mid-burst wait; their req_ready stays 0.
  - Both requests valid in IDLE: D wins in fixed-priority mode.
  - mem_req_ready is ignored outside CMD states.
- Reset mid-burst: immediate return to IDLE and the burst is abandoned. Beats still in flight from memory are discarded per the rule above.

Optional Feature:
- Macro: MEM_PORT_ARB_ROUND_ROBIN_EN.
  - Defined: a last-grant register (updated on each req_ready pulse) gives priority to the requester NOT granted last when both are valid.
  - Undefined: fixed D-over-I priority; the last-grant register is not synthesized.

Decomposition:
- Shared package (mips_core_pkg additions):
  - arb_state_t enum for the six states.
  - arb_owner_t enum {OWNER_I, OWNER_D}.
  - Constant MEM_LINE_WORDS.
- Natural sub-module: mem_port_arb_pick, combinational winner select (with optional round-robin input), kept separate for standalone unit testing.

Test Plan:
- Only i_req_valid=1, addr=0x100, LINE_WORDS=4, mem returns 4 beats 0xA0..0xA3 → i_req_ready pulse at cycle 1; mem_req_valid at cycle 2 with addr 0x100, write=0; i_rdata_valid on all 4 beats; IDLE after the 4th beat.
- d_req_valid=1, write=1, addr=0x200, d_wdata 0xD0..0xD3, mem_wdata_ready toggling 1/0 → exactly 4 transfers, in order, on mem_wdata; d_wdata_ready mirrors mem_wdata_ready.
- i and d valid in the same IDLE cycle, fixed priority → d granted first; i granted in the IDLE cycle after D's burst. With the macro and last-grant=D, i is granted first.
- mem_req_ready held 0 for 5 cycles in D_CMD → mem_req_valid/addr/write stable for all 5; no req_ready pulses to either cache.
- Stray mem_rdata_valid=1 in IDLE, then rst=1 asserted mid D_READ after 2 beats → no rdata_valid for the stray beat; all outputs 0 immediately on reset; after release, a new i request completes a full 4-beat burst.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
//==============================================================================
// Module   : mem_port_arbiter_pkg
// Desc     : Shared types and constants for the memory-port arbiter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package mem_port_arbiter_pkg;

    localparam int MEM_LINE_WORDS = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_I_CMD   = 3'd1,
        ST_D_CMD   = 3'd2,
        ST_I_READ  = 3'd3,
        ST_D_READ  = 3'd4,
        ST_D_WRITE = 3'd5
    } arb_state_t;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } arb_owner_t;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_pick.sv
//==============================================================================
// Module   : mem_port_arb_pick
// Desc     : Combinational winner select between i-cache and d-cache requests.
//            Optional macro: MEM_PORT_ARB_ROUND_ROBIN_EN (alternate on conflict).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_port_arb_pick (
`ifdef MEM_PORT_ARB_ROUND_ROBIN_EN
    input  logic last_d_i,
`endif
    input  logic i_valid_i,
    input  logic d_valid_i,
    output logic grant_i_o,
    output logic grant_d_o
);

    always_comb begin
`ifdef MEM_PORT_ARB_ROUND_ROBIN_EN
        // On a conflict, the side that did not win last time goes first.
        grant_d_o = d_valid_i && !(i_valid_i && last_d_i);
`else
        grant_d_o = d_valid_i;
`endif
        grant_i_o = i_valid_i && !grant_d_o;
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
//==============================================================================
// Module   : mem_port_arbiter
// Desc     : Shares one memory port between i-cache refills and d-cache
//            refill/writeback bursts. Optional macro: MEM_PORT_ARB_ROUND_ROBIN_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = MEM_LINE_WORDS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req_valid,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    output logic                  i_req_ready,
    output logic                  i_rdata_valid,
    input  logic                  d_req_valid,
    input  logic                  d_req_write,
    input  logic [ADDR_WIDTH-1:0] d_req_addr,
    output logic                  d_req_ready,
    input  logic                  d_wdata_valid,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_wdata_ready,
    output logic                  d_rdata_valid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_write,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic                  mem_wdata_valid,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_wdata_ready,
    input  logic                  mem_rdata_valid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int               CNT_W     = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);

    arb_state_t             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                   write_q, write_d;

    logic w_grant_i, w_grant_d;
    logic w_idle, w_cmd, w_i_rd, w_d_rd, w_wr, w_beat, w_last;

`ifdef MEM_PORT_ARB_ROUND_ROBIN_EN
    arb_owner_t last_q, last_d;
`endif

    mem_port_arb_pick u_pick (
`ifdef MEM_PORT_ARB_ROUND_ROBIN_EN
        .last_d_i  (last_q == OWNER_D),
`endif
        .i_valid_i (i_req_valid),
        .d_valid_i (d_req_valid),
        .grant_i_o (w_grant_i),
        .grant_d_o (w_grant_d)
    );

    // Grants are gated by rst so no ready pulse escapes while reset is held.
    assign w_idle = (state_q == ST_IDLE) && !rst;
    assign w_cmd  = (state_q == ST_I_CMD) || (state_q == ST_D_CMD);
    assign w_i_rd = (state_q == ST_I_READ);
    assign w_d_rd = (state_q == ST_D_READ);
    assign w_wr   = (state_q == ST_D_WRITE);
    assign w_last = (cnt_q == LAST_BEAT);
    assign w_beat = ((w_i_rd || w_d_rd) && mem_rdata_valid) ||
                    (w_wr && d_wdata_valid && mem_wdata_ready);

    assign i_req_ready     = w_idle && w_grant_i;
    assign d_req_ready     = w_idle && w_grant_d;
    assign mem_req_valid   = w_cmd;
    assign mem_req_write   = w_cmd && write_q;
    assign mem_req_addr    = addr_q;
    assign i_rdata_valid   = w_i_rd && mem_rdata_valid;
    assign d_rdata_valid   = w_d_rd && mem_rdata_valid;
    assign rdata           = mem_rdata;
    assign mem_wdata_valid = w_wr && d_wdata_valid;
    assign mem_wdata       = w_wr ? d_wdata : '0;
    assign d_wdata_ready   = w_wr && mem_wdata_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        unique case (state_q)
            ST_IDLE: begin
                if (w_grant_d) begin
                    addr_d  = d_req_addr;
                    write_d = d_req_write;
                    state_d = ST_D_CMD;
                end else if (w_grant_i) begin
                    addr_d  = i_req_addr;
                    write_d = 1'b0;
                    state_d = ST_I_CMD;
                end
            end
            ST_I_CMD: begin
                if (mem_req_ready) begin
                    state_d = ST_I_READ;
                    cnt_d   = '0;
                end
            end
            ST_D_CMD: begin
                if (mem_req_ready) begin
                    state_d = write_q ? ST_D_WRITE : ST_D_READ;
                    cnt_d   = '0;
                end
            end
            ST_I_READ, ST_D_READ, ST_D_WRITE: begin
                if (w_beat) begin
                    cnt_d = w_last ? '0 : cnt_q + 1'b1;
                    if (w_last) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef MEM_PORT_ARB_ROUND_ROBIN_EN
    always_comb begin
        last_d = last_q;
        if (d_req_ready) begin
            last_d = OWNER_D;
        end else if (i_req_ready) begin
            last_d = OWNER_I;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
`ifdef MEM_PORT_ARB_ROUND_ROBIN_EN
            last_q  <= OWNER_I;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
`ifdef MEM_PORT_ARB_ROUND_ROBIN_EN
            last_q  <= last_d;
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
//==============================================================================
// Module   : tb_mem_port_arbiter
// Desc     : Self-checking bench for mem_port_arbiter (default fixed priority).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        clk, rst;
    logic        i_req_valid, i_req_ready, i_rdata_valid;
    logic [25:0] i_req_addr;
    logic        d_req_valid, d_req_write, d_req_ready;
    logic [25:0] d_req_addr;
    logic        d_wdata_valid, d_wdata_ready, d_rdata_valid;
    logic [31:0] d_wdata, rdata;
    logic        mem_req_valid, mem_req_ready, mem_req_write;
    logic [25:0] mem_req_addr;
    logic        mem_wdata_valid, mem_wdata_ready, mem_rdata_valid;
    logic [31:0] mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        owner_d;
        logic [31:0] data;
    } rbeat_t;

    rbeat_t      rd_q[$];
    logic [31:0] wr_q[$];
    rbeat_t      rb;
    logic [31:0] wb;

    typedef struct {
        logic iv, dv, dw, mrv;
        logic e_ir, e_dr, e_cmd, e_write;
        logic [25:0] e_addr;
    } vec_t;

    vec_t vecs[8];

    mem_port_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .i_req_valid     (i_req_valid),
        .i_req_addr      (i_req_addr),
        .i_req_ready     (i_req_ready),
        .i_rdata_valid   (i_rdata_valid),
        .d_req_valid     (d_req_valid),
        .d_req_write     (d_req_write),
        .d_req_addr      (d_req_addr),
        .d_req_ready     (d_req_ready),
        .d_wdata_valid   (d_wdata_valid),
        .d_wdata         (d_wdata),
        .d_wdata_ready   (d_wdata_ready),
        .d_rdata_valid   (d_rdata_valid),
        .rdata           (rdata),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_write   (mem_req_write),
        .mem_req_addr    (mem_req_addr),
        .mem_wdata_valid (mem_wdata_valid),
        .mem_wdata       (mem_wdata),
        .mem_wdata_ready (mem_wdata_ready),
        .mem_rdata_valid (mem_rdata_valid),
        .mem_rdata       (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic iv, dv, dw, mrv, eir, edr, ecmd, ew,
                                input logic [25:0] ea);
        vec_t v;
        v.iv = iv; v.dv = dv; v.dw = dw; v.mrv = mrv;
        v.e_ir = eir; v.e_dr = edr; v.e_cmd = ecmd; v.e_write = ew; v.e_addr = ea;
        return v;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk1({tag, "_i_rdy"}, i_req_ready, L);
        chk1({tag, "_d_rdy"}, d_req_ready, L);
        chk1({tag, "_i_rv"}, i_rdata_valid, L);
        chk1({tag, "_d_rv"}, d_rdata_valid, L);
        chk1({tag, "_mreq_v"}, mem_req_valid, L);
        chk1({tag, "_mreq_w"}, mem_req_write, L);
        chkw({tag, "_mreq_a"}, {6'd0, mem_req_addr}, 32'd0);
        chk1({tag, "_mwd_v"}, mem_wdata_valid, L);
        chkw({tag, "_mwd"}, mem_wdata, 32'd0);
        chk1({tag, "_dwd_rdy"}, d_wdata_ready, L);
    endtask

    task automatic grant(input logic to_d, input logic wr);
        if (to_d) begin
            d_req_valid = 1'b1;
            d_req_write = wr;
        end else begin
            i_req_valid = 1'b1;
        end
        #2;
        chk1("grant_i", i_req_ready, !to_d);
        chk1("grant_d", d_req_ready, to_d);
        cyc();
        if (to_d) d_req_valid = 1'b0;
        else      i_req_valid = 1'b0;
        d_req_write = 1'b0;
    endtask

    task automatic cmd(input int hold, input logic [25:0] a, input logic wr);
        for (int k = 0; k <= hold; k++) begin
            mem_req_ready = (k == hold);
            #2;
            chk1("cmd_valid", mem_req_valid, H);
            chkw("cmd_addr", {6'd0, mem_req_addr}, {6'd0, a});
            chk1("cmd_write", mem_req_write, wr);
            chk1("cmd_no_i_rdy", i_req_ready, L);
            chk1("cmd_no_d_rdy", d_req_ready, L);
            cyc();
        end
        mem_req_ready = 1'b0;
    endtask

    task automatic read_beats(input logic to_d, input logic gaps, input int n,
                              input logic [31:0] base);
        for (int k = 0; k < n; k++) begin
            if (gaps && k[0]) begin
                mem_rdata_valid = 1'b0;
                #2;
                chk1("gap_i_rv", i_rdata_valid, L);
                chk1("gap_d_rv", d_rdata_valid, L);
                cyc();
            end
            mem_rdata_valid = 1'b1;
            mem_rdata       = base + 32'(k);
            rd_q.push_back('{to_d, base + 32'(k)});
            #2;
            chk1("burst_no_i_rdy", i_req_ready, L);
            chk1("burst_no_d_rdy", d_req_ready, L);
            cyc();
        end
        mem_rdata_valid = 1'b0;
    endtask

    task automatic stray_beat(input string tag);
        mem_rdata_valid = 1'b1;
        mem_rdata       = 32'hEEEE_EEEE;
        #2;
        chk1({tag, "_i_rv"}, i_rdata_valid, L);
        chk1({tag, "_d_rv"}, d_rdata_valid, L);
        cyc();
        mem_rdata_valid = 1'b0;
    endtask

    // Scoreboard: every beat the DUT forwards must match the oldest expected one.
    always @(negedge clk) begin
        if (i_rdata_valid || d_rdata_valid) begin
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got beat %0h expected none at %0t", rdata, $time);
            end else begin
                rb = rd_q.pop_front();
                chk1("rd_owner_d", d_rdata_valid, rb.owner_d);
                chk1("rd_owner_i", i_rdata_valid, !rb.owner_d);
                chkw("rd_data", rdata, rb.data);
            end
        end
        if (mem_wdata_valid && mem_wdata_ready) begin
            if (wr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_unexpected: got beat %0h expected none at %0t", mem_wdata, $time);
            end else begin
                wb = wr_q.pop_front();
                chkw("wr_data", mem_wdata, wb);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int idx;
        logic tog;

        vecs[0] = mk(L, L, L, L, L, L, L, L, 26'h000);
        vecs[1] = mk(H, L, L, L, H, L, H, L, 26'h100);
        vecs[2] = mk(L, H, L, L, L, H, H, L, 26'h200);
        vecs[3] = mk(L, H, H, L, L, H, H, H, 26'h200);
        vecs[4] = mk(H, H, H, L, L, H, H, H, 26'h200);
        vecs[5] = mk(H, L, L, H, H, L, H, L, 26'h100);
        vecs[6] = mk(H, L, H, L, H, L, H, L, 26'h100);
        vecs[7] = mk(H, H, L, H, L, H, H, L, 26'h200);

        i_req_addr      = 26'h100;
        d_req_addr      = 26'h200;
        rst             = 1'b1;
        i_req_valid     = 1'b1;
        d_req_valid     = 1'b1;
        d_req_write     = 1'b1;
        d_wdata_valid   = 1'b1;
        d_wdata         = 32'hFFFF_FFFF;
        mem_req_ready   = 1'b1;
        mem_wdata_ready = 1'b1;
        mem_rdata_valid = 1'b1;
        mem_rdata       = 32'h5555_5555;
        #2;
        check_zero("rst");
        cyc();
        cyc();
        check_zero("rst_hold");
        chkw("rdata_pass", rdata, 32'h5555_5555);
        i_req_valid     = 1'b0;
        d_req_valid     = 1'b0;
        d_req_write     = 1'b0;
        d_wdata_valid   = 1'b0;
        mem_req_ready   = 1'b0;
        mem_wdata_ready = 1'b0;
        mem_rdata_valid = 1'b0;
        cyc();
        rst = 1'b0;

        // Single-cycle arbitration vectors, each from a fresh IDLE.
        for (int v = 0; v < 8; v++) begin
            rst = 1'b1;
            cyc();
            rst = 1'b0;
            i_req_valid     = vecs[v].iv;
            d_req_valid     = vecs[v].dv;
            d_req_write     = vecs[v].dw;
            mem_rdata_valid = vecs[v].mrv;
            #2;
            chk1("vec_i_rdy", i_req_ready, vecs[v].e_ir);
            chk1("vec_d_rdy", d_req_ready, vecs[v].e_dr);
            chk1("vec_i_rv", i_rdata_valid, L);
            chk1("vec_d_rv", d_rdata_valid, L);
            chk1("vec_idle_mreq", mem_req_valid, L);
            cyc();
            i_req_valid     = 1'b0;
            d_req_valid     = 1'b0;
            d_req_write     = 1'b0;
            mem_rdata_valid = 1'b0;
            #2;
            chk1("vec_cmd_valid", mem_req_valid, vecs[v].e_cmd);
            chkw("vec_cmd_addr", {6'd0, mem_req_addr}, {6'd0, vecs[v].e_addr});
            chk1("vec_cmd_write", mem_req_write, vecs[v].e_write);
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;

        // i-cache refill, beats A0..A3, then a stray beat proves return to IDLE.
        grant(L, L);
        cmd(0, 26'h100, L);
        read_beats(L, L, 4, 32'hA0);
        stray_beat("after_i");

        // d-cache writeback with memory accepting every other cycle.
        grant(H, H);
        cmd(0, 26'h200, H);
        idx = 0;
        tog = 1'b1;
        for (int g = 0; g < 20 && idx < 4; g++) begin
            mem_wdata_ready = tog;
            d_wdata_valid   = 1'b1;
            d_wdata         = 32'hD0 + 32'(idx);
            if (tog) wr_q.push_back(32'hD0 + 32'(idx));
            #2;
            chk1("wr_mwd_v", mem_wdata_valid, H);
            chk1("wr_dwd_rdy", d_wdata_ready, tog);
            cyc();
            if (tog) idx++;
            tog = !tog;
        end
        mem_wdata_ready = 1'b1;
        d_wdata         = 32'hDD;
        #2;
        chk1("wr_done_mwd_v", mem_wdata_valid, L);
        chk1("wr_done_dwd_rdy", d_wdata_ready, L);
        chkw("wr_done_mwd", mem_wdata, 32'd0);
        cyc();
        d_wdata_valid   = 1'b0;
        mem_wdata_ready = 1'b0;

        // Both request together: D first with a stalled command, I right after.
        i_req_valid = 1'b1;
        d_req_valid = 1'b1;
        d_req_write = 1'b0;
        #2;
        chk1("both_d_rdy", d_req_ready, H);
        chk1("both_i_rdy", i_req_ready, L);
        cyc();
        d_req_valid = 1'b0;
        cmd(5, 26'h200, L);
        read_beats(H, H, 4, 32'hB0);
        #2;
        chk1("i_after_d", i_req_ready, H);
        cyc();
        i_req_valid = 1'b0;
        cmd(0, 26'h100, L);
        read_beats(L, L, 4, 32'hC0);

        // Stray beat in IDLE, then reset in the middle of a d-cache refill.
        stray_beat("idle_stray");
        grant(H, L);
        cmd(0, 26'h200, L);
        read_beats(H, L, 2, 32'h70);
        mem_rdata_valid = 1'b1;
        mem_rdata       = 32'hBAD0;
        i_req_valid     = 1'b1;
        d_req_valid     = 1'b1;
        rst             = 1'b1;
        #2;
        check_zero("mid_rst");
        cyc();
        check_zero("mid_rst_hold");
        i_req_valid     = 1'b0;
        d_req_valid     = 1'b0;
        rst             = 1'b0;
        #2;
        chk1("post_rst_i_rv", i_rdata_valid, L);
        chk1("post_rst_d_rv", d_rdata_valid, L);
        cyc();
        mem_rdata_valid = 1'b0;
        grant(L, L);
        cmd(0, 26'h100, L);
        read_beats(L, L, 4, 32'hE0);
        stray_beat("after_rst_burst");

        cyc();
        chkw("rd_q_empty", 32'(rd_q.size()), 32'd0);
        chkw("wr_q_empty", 32'(wr_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
